// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the byte FIFO write arbiter.
// Imported by the arbiter top and its round-robin picker.
package fifo_arb_pkg;

  localparam int N_REQ_DEF     = 4;
  localparam int MAX_BURST_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request bit
// strictly after last_grant, wrapping modulo N.
module rr_picker #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  always_comb begin : pick
    int idx;
    idx       = 0;
    grant_idx = '0;
    any       = 1'b0;
    // Walk from farthest to nearest so the nearest hit wins.
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % N;
      if (req[idx]) begin
        grant_idx = IW'(idx);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter locking one byte producer onto a byte FIFO
// for a burst ending on last or after MAX_BURST bytes.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ     = N_REQ_DEF,
  parameter  int MAX_BURST = MAX_BURST_DEF,
  localparam int IW        = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               fifo_w_en,
  output logic [7:0]         fifo_data,
  input  logic               fifo_full,
  output logic [IW-1:0]      grant_id,
  output logic               busy
);

  arb_state_t    state;
  arb_state_t    state_nx;
  logic [7:0]    beats;
  logic [7:0]    beats_nx;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] last_nx;
  logic [IW-1:0] grant_nx;
  logic [IW-1:0] pick;
  logic          any;
  logic          sel_valid;
  logic          sel_last;
  logic [7:0]    sel_data;
  logic          xfer;
  logic          done;

  rr_picker #(
    .N (N_REQ)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant_idx  (pick),
    .any        (any)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == IW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  assign xfer = (state == LOCK) & sel_valid & ~fifo_full;
  assign done = xfer &
    (sel_last | (({1'b0, beats} + 9'd1) == 9'(MAX_BURST)));

  always_comb begin
    state_nx  = state;
    beats_nx  = beats;
    grant_nx  = grant_id;
    last_nx   = last_grant;
    req_ready = '0;
    fifo_w_en = 1'b0;
    fifo_data = '0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (any) begin
          grant_nx = pick;
          beats_nx = '0;
          state_nx = LOCK;
        end
      end
      LOCK: begin
        busy      = 1'b1;
        fifo_w_en = xfer;
        fifo_data = sel_data;
        for (int i = 0; i < N_REQ; i++)
          req_ready[i] = (grant_id == IW'(i)) & ~fifo_full;
        if (xfer)
          beats_nx = beats + 8'd1;
        // Losing valid never releases; only last or the cap does.
        if (done) begin
          state_nx = IDLE;
          last_nx  = grant_id;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      beats      <= '0;
      grant_id   <= '0;
      last_grant <= IW'(N_REQ - 1);
    end else begin
      state      <= state_nx;
      beats      <= beats_nx;
      grant_id   <= grant_nx;
      last_grant <= last_nx;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with a burst-level
// reference model checked on every falling edge.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int MB = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [31:0]  req_data;
  logic [3:0]   req_last;
  logic [3:0]   req_ready;
  logic         fifo_w_en;
  logic [7:0]   fifo_data;
  logic         fifo_full;
  logic [1:0]   grant_id;
  logic         busy;

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .N_REQ     (N),
    .MAX_BURST (MB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .fifo_w_en (fifo_w_en),
    .fifo_data (fifo_data),
    .fifo_full (fifo_full),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  int vectors = 0;
  int miscompares = 0;

  bit         pv[4];
  int         pcnt[4];
  int         plen[4];
  logic [7:0] base[4] = '{8'h01, 8'h11, 8'h41, 8'h81};
  bit         full_in;

  int owner = -1;
  int m_gid = 0;
  int m_last = N - 1;
  int m_beats = 0;

  int seen[$];
  int gq[$];
  int gcyc[$];
  int wcount[4];
  int cyc = 0;
  bit prev_busy = 1'b0;
  bit mon_full = 1'b0;
  bit mon_hold = 1'b0;
  int full_bad = 0;
  int hold_bad = 0;

  function automatic logic [7:0] pbyte(int i);
    return 8'(int'(base[i]) + pcnt[i] * 17);
  endfunction

  function automatic bit plast(int i);
    return plen[i] != 0 && (pcnt[i] % plen[i]) == plen[i] - 1;
  endfunction

  function automatic int qget(int q[$], int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = pv[i];
      req_last[i]        = plast(i);
      req_data[8*i +: 8] = pbyte(i);
    end
    fifo_full = full_in;
  endtask

  task automatic cycle();
    bit         on;
    bit         e_wen;
    bit         l;
    logic [3:0] e_ready;
    logic [7:0] e_data;
    int         idx;
    drive();
    @(negedge clk);
    cyc++;
    if (rst) begin
      owner = -1; m_gid = 0; m_last = N - 1; m_beats = 0;
    end
    on = owner >= 0;
    e_ready = '0;
    e_wen = 1'b0;
    e_data = '0;
    if (on) begin
      if (!full_in) e_ready[owner] = 1'b1;
      e_wen  = pv[owner] && !full_in;
      e_data = pbyte(owner);
    end
    chk("busy", 32'(busy), 32'(on));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("fifo_w_en", 32'(fifo_w_en), 32'(e_wen));
    chk("fifo_data", 32'(fifo_data), 32'(e_data));
    if (busy && !prev_busy) begin
      gq.push_back(int'(grant_id));
      gcyc.push_back(cyc);
    end
    prev_busy = busy;
    if (fifo_w_en) begin
      seen.push_back(int'(fifo_data));
      wcount[grant_id]++;
    end
    if (mon_full && (fifo_w_en || req_ready != 0 || !busy)) full_bad++;
    if (mon_hold && (!busy || req_ready[0] || grant_id != 2'd1)) hold_bad++;
    if (!rst) begin
      if (!on) begin
        idx = m_last;
        for (int k = 0; k < N; k++) begin
          idx = (idx + 1) % N;
          if (pv[idx] && owner < 0) owner = idx;
        end
        if (owner >= 0) begin
          m_gid = owner;
          m_beats = 0;
        end
      end else if (e_wen) begin
        l = plast(owner);
        m_beats++;
        pcnt[owner]++;
        if (l || m_beats == MB) begin
          m_last = owner;
          owner = -1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_seq();
    rst = 1'b1;
    full_in = 1'b0;
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b0; pcnt[i] = 0; plen[i] = 0; wcount[i] = 0;
    end
    cycle();
    rst = 1'b0;
    seen.delete();
    gq.delete();
    gcyc.delete();
    for (int i = 0; i < N; i++) wcount[i] = 0;
  endtask

  initial begin
    rst = 1'b1;
    full_in = 1'b0;
    drive();
    reset_seq();
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Two-byte burst from producer 1, then producer 3 follows.
    pv[1] = 1'b1; plen[1] = 2;
    pv[3] = 1'b1; plen[3] = 2;
    cycle();
    chk("s1_grant", 32'(grant_id), 32'd1);
    chk("s1_busy", 32'(busy), 32'd1);
    cycle();
    cycle();
    chk("s1_idle", 32'(busy), 32'd0);
    chk("s1_nbytes", 32'(seen.size()), 32'd2);
    chk("s1_byte0", 32'(qget(seen, 0)), 32'h11);
    chk("s1_byte1", 32'(qget(seen, 1)), 32'h22);
    repeat (4) cycle();
    chk("s1_next", 32'(qget(gq, 1)), 32'd3);

    // Everyone valid, 3-byte bursts: strict rotation.
    reset_seq();
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b1; plen[i] = 3;
    end
    repeat (22) cycle();
    chk("s2_g0", 32'(qget(gq, 0)), 32'd0);
    chk("s2_g1", 32'(qget(gq, 1)), 32'd1);
    chk("s2_g2", 32'(qget(gq, 2)), 32'd2);
    chk("s2_g3", 32'(qget(gq, 3)), 32'd3);
    chk("s2_g4", 32'(qget(gq, 4)), 32'd0);
    chk("s2_period", 32'(qget(gcyc, 4) - qget(gcyc, 0)), 32'd16);

    // Endless stream from producer 2 capped at MAX_BURST.
    reset_seq();
    pv[2] = 1'b1;
    pv[3] = 1'b1; plen[3] = 2;
    repeat (21) cycle();
    chk("s3_cap", 32'(wcount[2]), 32'd16);
    chk("s3_next", 32'(qget(gq, 1)), 32'd3);
    chk("s3_p3", 32'(wcount[3]), 32'd2);

    // FIFO full for 5 cycles mid-burst.
    reset_seq();
    pv[0] = 1'b1;
    repeat (3) cycle();
    full_in = 1'b1;
    mon_full = 1'b1;
    repeat (5) cycle();
    mon_full = 1'b0;
    full_in = 1'b0;
    repeat (14) cycle();
    chk("s4_stall", 32'(full_bad), 32'd0);
    chk("s4_release", 32'(busy), 32'd0);
    chk("s4_nbytes", 32'(seen.size()), 32'd16);
    for (int k = 0; k < 16; k++)
      chk("s4_byte", 32'(qget(seen, k)), 32'((1 + 17 * k) % 256));

    // Granted producer drops valid; competitor must wait.
    reset_seq();
    pv[1] = 1'b1; plen[1] = 6;
    repeat (3) cycle();
    pv[1] = 1'b0;
    pv[0] = 1'b1;
    mon_hold = 1'b1;
    repeat (3) cycle();
    mon_hold = 1'b0;
    pv[1] = 1'b1;
    repeat (4) cycle();
    chk("s5_done", 32'(busy), 32'd0);
    cycle();
    chk("s5_hold", 32'(hold_bad), 32'd0);
    chk("s5_next", 32'(grant_id), 32'd0);
    chk("s5_nbytes", 32'(wcount[1]), 32'd6);

    // Reset mid-burst after the second byte.
    reset_seq();
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b1; plen[i] = 8;
    end
    repeat (3) cycle();
    rst = 1'b1;
    #1;
    chk("s6_wen", 32'(fifo_w_en), 32'd0);
    chk("s6_ready", 32'(req_ready), 32'd0);
    chk("s6_data", 32'(fifo_data), 32'd0);
    chk("s6_busy", 32'(busy), 32'd0);
    chk("s6_gid", 32'(grant_id), 32'd0);
    cycle();
    rst = 1'b0;
    cycle();
    chk("s6_regrant", 32'(grant_id), 32'd0);
    chk("s6_busy2", 32'(busy), 32'd1);
    repeat (2) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
